// File: rtl/fx1_issue_ctrl.sv
// FX1 issue control: latch ra/rb, fetch rt via a spare RF port when needed, drive the datapath, queue results for writeback.
// Latency 2 (2-op) / 4 (rt op, 3 with FX1_RT_FWD_EN forwarding); in_ready drops when the result FIFO cannot absorb another op.
module fx1_issue_ctrl #(
  parameter int OUT_DEPTH = 2,
  parameter int OPW       = 11,
  parameter int AW        = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_opcode,
  input  logic            in_needs_rt,
  input  logic [AW-1:0]   in_rt_addr,
  input  logic [127:0]    in_ra,
  input  logic [127:0]    in_rb,
  input  logic            flush,
  output logic            rt_rd_req,
  output logic [AW-1:0]   rt_rd_addr,
  input  logic [127:0]    rt_rd_data,
  output logic [OPW-1:0]  dp_op,
  output logic [127:0]    dp_ra,
  output logic [127:0]    dp_rb,
  output logic [127:0]    dp_rt,
  input  logic [127:0]    dp_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [AW-1:0]   wb_addr,
  output logic [127:0]    wb_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RDRT   = 2'd1;
  localparam logic [1:0] ST_RTWAIT = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [1:0]     state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [127:0]   ra_q, ra_d, rb_q, rb_d, rt_q, rt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  fa_q [OUT_DEPTH];
  logic [AW-1:0]  fa_d [OUT_DEPTH];
  logic [127:0]   fd_q [OUT_DEPTH];
  logic [127:0]   fd_d [OUT_DEPTH];

  logic           exec, pop, push, accept, hit;
  logic [CW:0]    occ;
  logic [CW-1:0]  wpos;
`ifdef FX1_RT_FWD_EN
  logic [127:0]   hit_dat;
`endif

  assign dp_op      = op_q;
  assign dp_ra      = ra_q;
  assign dp_rb      = rb_q;
  assign dp_rt      = rt_q;
  assign rt_rd_addr = addr_q;
  assign wb_valid   = (cnt_q != '0);
  assign wb_addr    = fa_q[0];
  assign wb_data    = fd_q[0];

  // Occupancy seen by a new op: the EXEC op will push, a popping head frees its slot now.
  always_comb begin
    exec     = (state_q == ST_EXEC);
    pop      = wb_valid & wb_ready;
    push     = exec & ~flush;
    occ      = {1'b0, cnt_q} + {{CW{1'b0}}, exec} - {{CW{1'b0}}, pop};
    in_ready = ~flush & ((state_q == ST_IDLE) | exec) & (occ < (CW+1)'(OUT_DEPTH));
    accept   = in_valid & in_ready;
  end

  // Entries are kept oldest-first, so the last match found is the youngest.
  always_comb begin
    hit = 1'b0;
`ifdef FX1_RT_FWD_EN
    hit_dat = '0;
`endif
    for (int i = 0; i < OUT_DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && (fa_q[i] == addr_q)) begin
        hit = 1'b1;
`ifdef FX1_RT_FWD_EN
        hit_dat = fd_q[i];
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rt_d      = rt_q;
    addr_d    = addr_q;
    rt_rd_req = 1'b0;
    case (state_q)
      ST_RDRT: begin
`ifdef FX1_RT_FWD_EN
        if (hit) begin
          rt_d    = hit_dat;
          state_d = ST_EXEC;
        end else begin
          rt_rd_req = 1'b1;
          state_d   = ST_RTWAIT;
        end
`else
        if (!hit) begin
          rt_rd_req = 1'b1;
          state_d   = ST_RTWAIT;
        end
`endif
      end
      ST_RTWAIT: begin
        rt_d    = rt_rd_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      op_d    = in_opcode;
      ra_d    = in_ra;
      rb_d    = in_rb;
      rt_d    = '0;
      addr_d  = in_rt_addr;
      state_d = in_needs_rt ? ST_RDRT : ST_EXEC;
    end
    if (flush) begin
      state_d   = ST_IDLE;
      rt_rd_req = 1'b0;
    end
  end

  always_comb begin
    fa_d  = fa_q;
    fd_d  = fd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wpos  = cnt_q - CW'(pop);
    if (pop) begin
      for (int i = 0; i < OUT_DEPTH - 1; i++) begin
        fa_d[i] = fa_q[i+1];
        fd_d[i] = fd_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (CW'(i) == wpos) begin
          fa_d[i] = addr_q;
          fd_d[i] = dp_result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rt_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fa_q[i] <= '0;
        fd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rt_q    <= rt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

endmodule

// File: tb/tb_fx1_issue_ctrl.sv
// Directed bench for fx1_issue_ctrl: reset, 2-op stream, bgx rt fetch, backpressure, RAW hazard, flush.
module tb_fx1_issue_ctrl;

  localparam int OPW = 11;
  localparam int AW  = 7;
  localparam logic [OPW-1:0] OP_XOR = 11'h001;
  localparam logic [OPW-1:0] OP_BGX = 11'h0C2;

  logic           clk;
  logic           rst_n;
  logic           in_valid, in_ready, in_needs_rt, flush;
  logic [OPW-1:0] in_opcode, dp_op;
  logic [AW-1:0]  in_rt_addr, rt_rd_addr, wb_addr;
  logic [127:0]   in_ra, in_rb, rt_rd_data, dp_ra, dp_rb, dp_rt, dp_result, wb_data;
  logic           rt_rd_req, wb_valid, wb_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] t2_exp [4] = '{128'h12, 128'h21, 128'h30, 128'h47};
  logic [127:0] res_a  = 128'h00000001_00000000_00000000_00000055;

  fx1_issue_ctrl #(.OUT_DEPTH(2), .OPW(OPW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_needs_rt(in_needs_rt),
    .in_rt_addr(in_rt_addr), .in_ra(in_ra), .in_rb(in_rb), .flush(flush),
    .rt_rd_req(rt_rd_req), .rt_rd_addr(rt_rd_addr), .rt_rd_data(rt_rd_data),
    .dp_op(dp_op), .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_rt(dp_rt), .dp_result(dp_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: each 32-bit word holds the register number.
  always @(posedge clk) rt_rd_data <= rt_rd_req ? {4{25'd0, rt_rd_addr}} : '0;

  // Datapath: bgx per word, everything else xor.
  always_comb begin
    dp_result = '0;
    if (dp_op == OP_BGX) begin
      for (int w = 0; w < 4; w++)
        dp_result[32*w +: 32] = ((dp_rb[32*w +: 32] > dp_ra[32*w +: 32]) ||
                                 ((dp_rb[32*w +: 32] == dp_ra[32*w +: 32]) && dp_rt[32*w])) ? 32'd1 : 32'd0;
    end else begin
      dp_result = dp_ra ^ dp_rb;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic [OPW-1:0] op, input logic nrt, input logic [AW-1:0] a,
                       input logic [127:0] ra, input logic [127:0] rb);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_needs_rt = nrt;
    in_rt_addr  = a;
    in_ra       = ra;
    in_rb       = rb;
  endtask

  task automatic idle;
    in_valid    = 1'b0;
    in_needs_rt = 1'b0;
  endtask

  task automatic gap(input int n);
    idle();
    flush = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_needs_rt = 1'b0; in_rt_addr = '0;
    in_ra = '0; in_rb = '0; flush = 1'b0; wb_ready = 1'b1;
    cyc(); cyc();
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_rd_req", rt_rd_req, 1'b0);
    check("rst_dp_op", dp_op, '0);
    check("rst_dp_rt", dp_rt, '0);
    check("rst_in_ready", in_ready, 1'b1);

    // T1: reset while an op is in EXEC
    rst_n = 1'b1;
    cyc(); drive(OP_XOR, 1'b0, 7'd5, 128'h1, 128'h2); settle();
    check("t1_rdy_c0", in_ready, 1'b1);
    cyc(); idle(); settle();
    check("t1_dp_op_exec", dp_op, OP_XOR);
    rst_n = 1'b0; #1;
    check("t1_rst_wb_valid", wb_valid, 1'b0);
    check("t1_rst_dp_ra", dp_ra, '0);
    check("t1_rst_in_ready", in_ready, 1'b1);
    cyc(); rst_n = 1'b1; settle();
    check("t1_post_wb_valid", wb_valid, 1'b0);
    check("t1_post_rdy", in_ready, 1'b1);
    cyc();
    check("t1_post2_wb_valid", wb_valid, 1'b0);
    gap(2);

    // T2: four back-to-back 2-operand ops
    wb_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (c < 4) drive(OP_XOR, 1'b0, 7'(c + 1), 128'(17 * (c + 1)), 128'h3);
      else idle();
      settle();
      if (c < 4) check($sformatf("t2_rdy_c%0d", c), in_ready, 1'b1);
      if (c >= 2 && c <= 5) begin
        check($sformatf("t2_vld_c%0d", c), wb_valid, 1'b1);
        check($sformatf("t2_addr_c%0d", c), wb_addr, 128'(c - 1));
        check($sformatf("t2_data_c%0d", c), wb_data, t2_exp[c-2]);
      end else begin
        check($sformatf("t2_novld_c%0d", c), wb_valid, 1'b0);
      end
    end
    gap(2);

    // T3: bgx with rt fetch
    cyc(); drive(OP_BGX, 1'b1, 7'd9, {4{32'd5}}, {4{32'd5}}); settle();
    check("t3_rdy_c0", in_ready, 1'b1);
    cyc(); idle(); settle();
    check("t3_req_c1", rt_rd_req, 1'b1);
    check("t3_raddr_c1", rt_rd_addr, 7'd9);
    check("t3_rdy_c1", in_ready, 1'b0);
    cyc();
    check("t3_req_c2", rt_rd_req, 1'b0);
    cyc();
    check("t3_dp_rt_c3", dp_rt, {4{32'd9}});
    check("t3_vld_c3", wb_valid, 1'b0);
    cyc();
    check("t3_vld_c4", wb_valid, 1'b1);
    check("t3_addr_c4", wb_addr, 7'd9);
    check("t3_data_c4", wb_data, {4{32'd1}});
    cyc();
    check("t3_vld_c5", wb_valid, 1'b0);
    gap(2);

    // T4: backpressure with a 2-entry FIFO
    wb_ready = 1'b0;
    cyc(); drive(OP_XOR, 1'b0, 7'd20, 128'hA0, 128'h0); settle();
    check("t4_rdy_c0", in_ready, 1'b1);
    cyc(); drive(OP_XOR, 1'b0, 7'd21, 128'hA1, 128'h0); settle();
    check("t4_rdy_c1", in_ready, 1'b1);
    check("t4_dp_rt_zero", dp_rt, '0);
    cyc(); drive(OP_XOR, 1'b0, 7'd22, 128'hA2, 128'h0); settle();
    check("t4_rdy_c2", in_ready, 1'b0);
    check("t4_vld_c2", wb_valid, 1'b1);
    check("t4_addr_c2", wb_addr, 7'd20);
    cyc(); settle();
    check("t4_rdy_c3", in_ready, 1'b0);
    check("t4_addr_c3", wb_addr, 7'd20);
    check("t4_data_c3", wb_data, 128'hA0);
    cyc(); wb_ready = 1'b1; settle();
    check("t4_rdy_c4", in_ready, 1'b1);
    check("t4_addr_c4", wb_addr, 7'd20);
    cyc(); idle(); settle();
    check("t4_addr_c5", wb_addr, 7'd21);
    check("t4_data_c5", wb_data, 128'hA1);
    cyc();
    check("t4_addr_c6", wb_addr, 7'd22);
    check("t4_data_c6", wb_data, 128'hA2);
    cyc();
    check("t4_vld_c7", wb_valid, 1'b0);
    gap(2);

    // T5: rt op reads a register still queued in the FIFO
    wb_ready = 1'b0;
    cyc(); drive(OP_XOR, 1'b0, 7'd12, 128'h00000001_00000000_00000000_0000005A, 128'h0F); settle();
    cyc(); idle(); settle();
    cyc(); drive(OP_BGX, 1'b1, 7'd12, {32'd7, 32'd7, 32'd3, 32'd9}, {32'd7, 32'd7, 32'd4, 32'd2}); settle();
    check("t5_rdy_c2", in_ready, 1'b1);
    cyc(); idle(); settle();
    check("t5_req_c3", rt_rd_req, 1'b0);
    check("t5_rdy_c3", in_ready, 1'b0);
`ifdef FX1_RT_FWD_EN
    cyc();
    check("t5f_dp_rt_c4", dp_rt, res_a);
    check("t5f_req_c4", rt_rd_req, 1'b0);
    cyc(); wb_ready = 1'b1; settle();
    check("t5f_addr_c5", wb_addr, 7'd12);
    check("t5f_data_c5", wb_data, res_a);
    cyc();
    check("t5f_addr_c6", wb_addr, 7'd12);
    check("t5f_data_c6", wb_data, 128'h00000001_00000000_00000001_00000000);
    cyc();
    check("t5f_vld_c7", wb_valid, 1'b0);
`else
    cyc();
    check("t5_req_c4", rt_rd_req, 1'b0);
    cyc(); wb_ready = 1'b1; settle();
    check("t5_req_c5", rt_rd_req, 1'b0);
    check("t5_addr_c5", wb_addr, 7'd12);
    check("t5_data_c5", wb_data, res_a);
    cyc();
    check("t5_req_c6", rt_rd_req, 1'b1);
    check("t5_raddr_c6", rt_rd_addr, 7'd12);
    check("t5_vld_c6", wb_valid, 1'b0);
    cyc();
    check("t5_req_c7", rt_rd_req, 1'b0);
    cyc();
    check("t5_dp_rt_c8", dp_rt, {4{32'd12}});
    cyc();
    check("t5_addr_c9", wb_addr, 7'd12);
    check("t5_data_c9", wb_data, 128'h00000000_00000000_00000001_00000000);
    cyc();
    check("t5_vld_c10", wb_valid, 1'b0);
`endif
    gap(2);

    // T6: flush while waiting for RF data
    wb_ready = 1'b0;
    cyc(); drive(OP_XOR, 1'b0, 7'd30, 128'h77, 128'h0); settle();
    cyc(); drive(OP_BGX, 1'b1, 7'd31, 128'h0, 128'h0); settle();
    check("t6_rdy_c1", in_ready, 1'b1);
    cyc(); idle(); settle();
    check("t6_req_c2", rt_rd_req, 1'b1);
    cyc(); flush = 1'b1; settle();
    check("t6_rdy_flush_c3", in_ready, 1'b0);
    cyc(); flush = 1'b0; settle();
    check("t6_rdy_idle_c4", in_ready, 1'b1);
    check("t6_req_c4", rt_rd_req, 1'b0);
    check("t6_addr_c4", wb_addr, 7'd30);
    cyc(); flush = 1'b1; wb_ready = 1'b1; drive(OP_XOR, 1'b0, 7'd33, 128'h5, 128'h0); settle();
    check("t6_rdy_vld_flush_c5", in_ready, 1'b0);
    check("t6_addr_c5", wb_addr, 7'd30);
    check("t6_data_c5", wb_data, 128'h77);
    cyc(); flush = 1'b0; idle(); settle();
    check("t6_vld_c6", wb_valid, 1'b0);
    cyc();
    check("t6_vld_c7", wb_valid, 1'b0);
    gap(2);

    // T7: flush during EXEC drops that cycle's push
    wb_ready = 1'b1;
    cyc(); drive(OP_XOR, 1'b0, 7'd40, 128'h9, 128'h0); settle();
    cyc(); idle(); flush = 1'b1; settle();
    check("t7_dp_op_exec", dp_op, OP_XOR);
    cyc(); flush = 1'b0; settle();
    check("t7_vld_c2", wb_valid, 1'b0);
    check("t7_rdy_c2", in_ready, 1'b1);
    cyc();
    check("t7_vld_c3", wb_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
